// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage IEEE-754 single-precision float to signed 32-bit
// integer converter with valid/ready flow control on both sides.
// Stage 1 decodes the operand; stage 2 aligns, rounds, negates and
// saturates into the output registers.
module ftoi_pipe #(
    parameter bit TRUNC = 1'b0   // 0: nearest, ties away from zero; 1: toward zero
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        x_valid,
    output logic        x_ready,
    output logic [31:0] y,
    output logic        y_valid,
    input  logic        y_ready,
    output logic        ovf
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,   // zero or denormal
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    logic               vld_p1;
    logic               vld_p2;
    logic               sign_p1;
    logic signed [8:0]  e_p1;
    logic [23:0]        sig_p1;
    cls_t               cls_p1;
    logic [32:0]        res_p1;
    logic               adv1;
    logic               adv2;

    function automatic cls_t classify(input logic [7:0] exp, input logic [22:0] man);
        cls_t c;
        if (exp == 8'd0)
            c = CLS_ZERO;
        else if (exp == 8'hFF)
            c = (man != 23'd0) ? CLS_NAN : CLS_INF;
        else
            c = CLS_NORM;
        return c;
    endfunction

    // Magnitude for in-range exponents (e <= 30). Right shifts keep one
    // guard bit below the binary point; e == -1 falls out of the same path
    // because the guard bit is then the hidden one.
    function automatic logic [31:0] round_mag(input logic signed [8:0] e,
                                              input logic [23:0] sig);
        logic [32:0] tmp;
        logic [31:0] mag;
        logic [4:0]  rsh;
        logic [2:0]  lsh;
        tmp = '0;
        mag = '0;
        rsh = '0;
        lsh = '0;
        if (e <= -9'sd2) begin
            mag = 32'd0;
        end else if (e <= 9'sd22) begin
            rsh = 5'(9'sd23 - e);
            tmp = {8'd0, sig, 1'b0} >> rsh;
            mag = tmp[32:1];
            if (!TRUNC && tmp[0])
                mag = mag + 32'd1;
        end else begin
            lsh = 3'(e - 9'sd23);
            mag = {8'd0, sig} << lsh;
        end
        return mag;
    endfunction

    // Final result {ovf, y}: special classes, range saturation, sign.
    function automatic logic [32:0] saturate(input logic sign,
                                             input logic signed [8:0] e,
                                             input logic [23:0] sig,
                                             input cls_t cls);
        logic [32:0] r;
        logic [31:0] mag;
        logic [31:0] sat;
        sat = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        mag = '0;
        r   = '0;
        case (cls)
            CLS_ZERO: r = {1'b0, 32'd0};
            CLS_NAN:  r = {1'b1, 32'h7FFF_FFFF};
            CLS_INF:  r = {1'b1, sat};
            default: begin
                if (e >= 9'sd31) begin
                    if (sign && e == 9'sd31 && sig == 24'h80_0000)
                        r = {1'b0, 32'h8000_0000};
                    else
                        r = {1'b1, sat};
                end else begin
                    mag = round_mag(e, sig);
                    r = {1'b0, sign ? (32'd0 - mag) : mag};
                end
            end
        endcase
        return r;
    endfunction

    assign adv2    = !vld_p2 || y_ready;
    assign adv1    = !vld_p1 || adv2;
    assign x_ready = adv1;
    assign y_valid = vld_p2;
    assign res_p1  = saturate(sign_p1, e_p1, sig_p1, cls_p1);

    // Stage occupancy: a stage refills whenever its downstream can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv1)
                vld_p1 <= x_valid;
            if (adv2)
                vld_p2 <= vld_p1;
        end
    end

    // ---- stage 0 -> 1: decode sign, unbiased exponent, significand, class
    always_ff @(posedge clk) begin
        if (adv1 && x_valid) begin
            sign_p1 <= x[31];
            e_p1    <= $signed({1'b0, x[30:23]}) - 9'sd127;
            sig_p1  <= {1'b1, x[22:0]};
            cls_p1  <= classify(x[30:23], x[22:0]);
        end
    end

    // ---- stage 1 -> 2: result registers, cleared so no stale value shows after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= 32'd0;
            ovf <= 1'b0;
        end else if (adv2 && vld_p1) begin
            ovf <= res_p1[32];
            y   <= res_p1[31:0];
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe: drives one TRUNC=0 and one TRUNC=1 converter from the same
// operand stream and checks both against a real-arithmetic reference model.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x;
    logic        x_valid;
    logic        y_ready;
    logic        x_ready0, x_ready1;
    logic [31:0] y0, y1;
    logic        yv0, yv1;
    logic        ovf0, ovf1;

    always #5 clk = ~clk;

    ftoi_pipe #(.TRUNC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready0),
        .y(y0), .y_valid(yv0), .y_ready(y_ready), .ovf(ovf0));

    ftoi_pipe #(.TRUNC(1'b1)) dut1 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready1),
        .y(y1), .y_valid(yv1), .y_ready(y_ready), .ovf(ovf1));

    typedef struct {
        logic [31:0] x;
        logic [31:0] y0;
        logic        o0;
        logic [31:0] y1;
        logic        o1;
        int          k;
        bit          kchk;
    } op_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        o;
        int          acyc;
        int          k;
        bit          kchk;
    } res_t;

    op_t  in_q[$];
    res_t q0[$];
    res_t q1[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    int   xr_exp = -1;
    int   yv_exp = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Reference: value of the float as a real, rounded, then range-limited.
    function automatic logic [32:0] model(input logic [31:0] xb, input bit trunc);
        real r, rv;
        int  ex;
        ex = int'({24'd0, xb[30:23]});
        if (ex == 255) begin
            if (xb[22:0] != 23'd0) return {1'b1, 32'h7FFF_FFFF};
            return {1'b1, xb[31] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        if (ex == 0)
            r = real'(int'({9'd0, xb[22:0]})) * (2.0 ** -149.0);
        else
            r = (1.0 + real'(int'({9'd0, xb[22:0]})) / 8388608.0) * (2.0 ** real'(ex - 127));
        rv = trunc ? $floor(r) : $floor(r + 0.5);
        if (xb[31]) rv = -rv;
        if (rv >= 2147483648.0) return {1'b1, 32'h7FFF_FFFF};
        if (rv < -2147483648.0) return {1'b1, 32'h8000_0000};
        return {1'b0, 32'($rtoi(rv))};
    endfunction

    // Integer to float, round to nearest even (what itof produces).
    function automatic logic [31:0] itof(input int k);
        longint m, q, rem, half;
        int     p, sh;
        logic   s;
        if (k == 0) return 32'd0;
        s = (k < 0);
        m = s ? -longint'(k) : longint'(k);
        p = 0;
        for (int i = 0; i < 33; i++) if (m[i]) p = i;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(127 + p), q[22:0]};
    endfunction

    task automatic push_dir(input logic [31:0] xb, input logic [31:0] ya, input logic oa,
                            input logic [31:0] yb, input logic ob);
        in_q.push_back('{x: xb, y0: ya, o0: oa, y1: yb, o1: ob, k: 0, kchk: 1'b0});
    endtask

    task automatic push_model(input logic [31:0] xb);
        logic [32:0] m0, m1;
        m0 = model(xb, 1'b0);
        m1 = model(xb, 1'b1);
        in_q.push_back('{x: xb, y0: m0[31:0], o0: m0[32], y1: m1[31:0], o1: m1[32], k: 0, kchk: 1'b0});
    endtask

    task automatic push_k(input int k);
        logic [32:0] m0, m1;
        logic [31:0] xb;
        xb = itof(k);
        m0 = model(xb, 1'b0);
        m1 = model(xb, 1'b1);
        in_q.push_back('{x: xb, y0: m0[31:0], o0: m0[32], y1: m1[31:0], o1: m1[32], k: k,
                         kchk: (k <= 16777216 && k >= -16777216)});
    endtask

    task automatic observe(input int i, input logic yv, input logic [31:0] yo, input logic o);
        res_t e;
        if (!yv) return;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            check($sformatf("spurious_valid%0d", i), 32'(yv), 32'd0);
            return;
        end
        e = (i == 0) ? q0[0] : q1[0];
        check($sformatf("y%0d x=%08h", i, e.x), yo, e.y);
        check($sformatf("ovf%0d x=%08h", i, e.x), 32'(o), 32'(e.o));
        if (e.kchk) begin
            check($sformatf("roundtrip%0d k=%0d", i, e.k), yo, 32'(e.k));
            check($sformatf("roundtrip_ovf%0d k=%0d", i, e.k), 32'(o), 32'd0);
        end
        if (y_ready) begin
            if (lat_chk) check($sformatf("latency%0d", i), 32'(cyc - e.acyc), 32'd2);
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, update queues at posedge.
    task automatic cycle(input bit yr, input bit offer);
        bit  acc;
        int  c;
        op_t op;
        @(negedge clk);
        y_ready = yr;
        x_valid = offer && (in_q.size() > 0);
        x = x_valid ? in_q[0].x : $urandom();
        #1;
        c   = cyc;
        acc = x_valid && x_ready0;
        if (xr_exp >= 0) check("x_ready", 32'(x_ready0), 32'(xr_exp));
        if (yv_exp >= 0) check("y_valid_nogap", 32'(yv0), 32'(yv_exp));
        check("tr1_valid_align", 32'(yv1), 32'(yv0));
        observe(0, yv0, y0, ovf0);
        observe(1, yv1, y1, ovf1);
        cyc++;
        @(posedge clk);
        if (acc) begin
            op = in_q.pop_front();
            q0.push_back('{x: op.x, y: op.y0, o: op.o0, acyc: c, k: op.k, kchk: op.kchk});
            q1.push_back('{x: op.x, y: op.y1, o: op.o1, acyc: c, k: op.k, kchk: op.kchk});
        end
    endtask

    task automatic drain(input bit rnd, input int maxc);
        int n;
        n = 0;
        while ((in_q.size() + q0.size() + q1.size()) > 0 && n < maxc) begin
            if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            else     cycle(1'b1, 1'b1);
            n++;
        end
        check("drain_empty", 32'(in_q.size() + q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        x = 32'd0;
        x_valid = 1'b0;
        y_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_y_valid", 32'(yv0), 32'd0);
        check("rst_y", y0, 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_x_ready", 32'(x_ready0), 32'd1);
        rst = 1'b0;

        // Streaming with latency check
        lat_chk = 1'b1;
        push_dir(32'h4020_0000, 32'd3,          1'b0, 32'd2,          1'b0);
        push_dir(32'hC020_0000, 32'hFFFF_FFFD,  1'b0, 32'hFFFF_FFFE,  1'b0);
        push_dir(32'h3FC0_0000, 32'd2,          1'b0, 32'd1,          1'b0);
        push_dir(32'h4B7F_FFFF, 32'd16777215,   1'b0, 32'd16777215,   1'b0);
        drain(1'b0, 50);
        lat_chk = 1'b0;

        // Small values
        push_dir(32'h3F00_0000, 32'd1, 1'b0, 32'd0, 1'b0);
        push_dir(32'h3EFF_FFFF, 32'd0, 1'b0, 32'd0, 1'b0);
        push_dir(32'h8000_0000, 32'd0, 1'b0, 32'd0, 1'b0);
        push_dir(32'h0000_0001, 32'd0, 1'b0, 32'd0, 1'b0);
        // Range limits and specials
        push_dir(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 32'h7FFF_FF80, 1'b0);
        push_dir(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        push_dir(32'hCF00_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
        push_dir(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        push_dir(32'hFF80_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);
        push_dir(32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        drain(1'b0, 50);

        // Backpressure: three stalled cycles, then release
        push_dir(32'h3F80_0000, 32'd1, 1'b0, 32'd1, 1'b0);
        push_dir(32'h4000_0000, 32'd2, 1'b0, 32'd2, 1'b0);
        push_dir(32'h4040_0000, 32'd3, 1'b0, 32'd3, 1'b0);
        push_dir(32'h4080_0000, 32'd4, 1'b0, 32'd4, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check("bp_two_accepts", 32'(in_q.size()), 32'd2);
        xr_exp = 0;
        cycle(1'b0, 1'b1);
        xr_exp = -1;
        yv_exp = 1;
        repeat (4) cycle(1'b1, 1'b1);
        yv_exp = -1;
        drain(1'b0, 20);

        // Reset with two results in flight
        push_dir(32'h3F80_0000, 32'd1, 1'b0, 32'd1, 1'b0);
        push_dir(32'h4000_0000, 32'd2, 1'b0, 32'd2, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        x_valid = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_y_valid0", 32'(yv0), 32'd0);
        check("midrst_y_valid1", 32'(yv1), 32'd0);
        check("midrst_y", y0, 32'd0);
        rst = 1'b0;
        in_q.delete();
        q0.delete();
        q1.delete();
        push_dir(32'h4120_0000, 32'd10, 1'b0, 32'd10, 1'b0);
        drain(1'b0, 20);

        // Round trip of integers through itof, random handshakes
        for (int k = -40; k <= 40; k++) push_k(k);
        push_k(16777216);
        push_k(-16777216);
        push_k(16777215);
        push_k(16777217);
        push_k(-10000000);
        push_k(1000000);
        for (int i = 0; i < 1500; i++) push_k(-10000000 + int'($urandom_range(0, 11000000)));
        drain(1'b1, 20000);

        // Random float bit patterns, biased toward the interesting exponent band
        for (int i = 0; i < 200; i++) push_model($urandom());
        for (int i = 0; i < 300; i++)
            push_model({1'($urandom()), 8'($urandom_range(120, 160)), 23'($urandom())});
        drain(1'b1, 8000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined IEEE-754 single-precision float to signed 32-bit integer converter; inverse of the combinational itof unit.
- Sits in the FPU execute path beside itof and drives the integer writeback for the ftoi instruction.
- Two register stages with a valid/ready handshake on both sides, so it can stall under writeback backpressure.

Parameters:
- TRUNC, 0: rounding mode. 0 = round to nearest, ties away from zero. 1 = truncate toward zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- x  in  32  float operand {sign, exp[7:0], man[22:0]}
- x_valid  in  1  operand valid
- x_ready  out  1  converter can accept an operand this cycle
- y  out  32  signed integer result
- y_valid  out  1  result valid
- y_ready  in  1  consumer accepts the result
- ovf  out  1  result saturated (out of range, inf or NaN); qualified by y_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
- Reset values: stage valids 0, y_valid 0, y 0, ovf 0. In-flight operands are discarded.
- Reset mid-operation: y_valid is 0 the cycle after rst is sampled high. No stale result is presented afterwards.
- Handshake:
  - A transfer occurs on the edge where valid && ready.
  - adv2 = !v2 || y_ready.
  - adv1 = !v1 || adv2.
  - x_ready = adv1, combinational from y_ready. There is no bubble when streaming.
- Latency: an operand accepted at edge N gives y_valid=1 after edge N+2 if not stalled. Throughput is 1 per cycle.
- Stall: while y_valid && !y_ready, y, ovf and y_valid hold stable. Stage 1 holds if it is occupied. No loss, duplication or reordering.
- Stage 1 (decode):
  - Register sign and e = exp-127.
  - Register the 24-bit significand {1, man}.
  - Register the class: zero/denormal, normal, inf, NaN.
- Stage 2 (align/round/negate/saturate): output registers y and ovf.
- Arithmetic rules:
  - exp==0 (zero or denormal): y=0, ovf=0. Negative zero gives 0.
  - e<=-2: y=0.
  - e==-1: y=±1 when TRUNC=0, else 0.
  - 0<=e<=22: magnitude = significand >> (23-e).
    - When TRUNC=0, add 1 if the first discarded bit is 1 (ties away).
    - Maximum magnitude is 2^23, so no overflow is possible here.
  - 23<=e<=30: magnitude = significand << (e-23). Exact.
  - Apply sign as two's complement.
  - e>=31 with x==0xCF000000: y=0x80000000, ovf=0 (exact -2^31).
  - Other e>=31: y=0x7FFFFFFF if sign=0, else 0x80000000; ovf=1.
  - Infinity: saturate by sign, ovf=1.
  - NaN (exp=255, man!=0): y=0x7FFFFFFF regardless of sign, ovf=1.
- Simultaneous events: accepting a new operand and emitting a result in the same cycle is legal, and all stages shift.
- Inputs: x_valid low leaves x don't-care. x must be stable only at the accepting edge.

Test Plan:
1. TRUNC=0, continuous stream with y_ready=1:
   - 0x40200000 (2.5) -> 3.
   - 0xC0200000 -> 0xFFFFFFFD.
   - 0x3FC00000 (1.5) -> 2.
   - 0x4B7FFFFF -> 16777215.
   - Each y_valid exactly 2 cycles after acceptance, back-to-back.
2. Small values:
   - 0x3F000000 (0.5) -> 1.
   - 0x3EFFFFFF -> 0.
   - 0x80000000 -> 0.
   - 0x00000001 -> 0.
   - With TRUNC=1: 0x40200000 -> 2 and 0xC0200000 -> 0xFFFFFFFE.
3. Range limits:
   - 0x4EFFFFFF -> 0x7FFFFF80, ovf=0.
   - 0x4F000000 -> 0x7FFFFFFF, ovf=1.
   - 0xCF000000 -> 0x80000000, ovf=0.
   - 0x7F800000 -> 0x7FFFFFFF, ovf=1.
   - 0xFF800000 -> 0x80000000, ovf=1.
   - 0xFFC00000 -> 0x7FFFFFFF, ovf=1.
4. Backpressure:
   - Offer 4 operands (1.0, 2.0, 3.0, 4.0) with y_ready held 0 for 3 cycles.
   - x_ready falls after 2 accepts and y holds 1 while stalled.
   - On release, outputs are 1, 2, 3, 4 in order, with no gaps or duplicates.
5. Reset: assert rst for 1 cycle while 2 results are in flight -> y_valid=0, y=0 the next cycle. Subsequent operand 0x41200000 -> 10.
6. Round-trip sweep against itof:
   - For k in -10000000..1000000, feed itof(k) with random y_ready.
   - Compare against a golden model of round(float(k)) with ties away.
   - Must equal k for |k|<=2^24, and ovf is never set.
